// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
//
// Push-button conditioner for the digital clock front panel. Each raw,
// bouncy, active-low button is synchronised, debounced and turned into a
// registered debounced level plus a one-cycle event strobe. A press event is
// (flag && !state) and a release event is (flag && state). With HOLD_MAX != 0,
// a held key also emits repeat strobes that look like fresh presses.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   i_key_in     raw button levels, asynchronous to clk, 0 = pressed
//   o_key_flag   one-cycle strobe per debounced event (press, release, repeat)
//   o_key_state  debounced level, 1 = released, 0 = pressed
//
// Parameters
//   KEY_NUM      number of independent channels
//   CNT_MAX      debounce window in clk cycles (>= 2)
//   HOLD_MAX     cycles from press strobe to first repeat strobe, 0 = no repeat
//   REPEAT_MAX   cycles between later repeat strobes (>= 1)
// -----------------------------------------------------------------------------
module key_filter #(
   parameter int KEY_NUM    = 3,
   parameter int CNT_MAX    = 1_000_000,
   parameter int HOLD_MAX   = 50_000_000,
   parameter int REPEAT_MAX = 10_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] i_key_in,
   output logic [KEY_NUM-1:0] o_key_flag,
   output logic [KEY_NUM-1:0] o_key_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FILT_DN = 2'd1;
   localparam logic [1:0] ST_DOWN    = 2'd2;
   localparam logic [1:0] ST_FILT_UP = 2'd3;

   localparam int CNT_W     = $clog2(CNT_MAX);
   localparam int HOLD_SPAN = (HOLD_MAX > REPEAT_MAX) ? HOLD_MAX : REPEAT_MAX;
   localparam int HOLD_W    = (HOLD_SPAN > 1) ? $clog2(HOLD_SPAN) : 1;
   localparam bit REPEAT_EN = (HOLD_MAX != 0);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_MAX - 1);

   for (genvar g = 0; g < KEY_NUM; g++) begin : g_chan
      logic              r_s1;
      logic              r_s2;
      logic [1:0]        r_state;
      logic [CNT_W-1:0]  r_cnt;
      logic [HOLD_W-1:0] r_hold;
      logic              r_rep;       // first repeat already issued in this hold
      logic              r_flag;
      logic              r_kstate;

      logic [1:0]        w_state_nxt;
      logic [CNT_W-1:0]  w_cnt_nxt;
      logic [HOLD_W-1:0] w_hold_nxt;
      logic              w_rep_nxt;
      logic              w_flag_nxt;
      logic              w_kstate_nxt;
      logic [HOLD_W-1:0] w_hold_target;
      logic              w_cnt_done;

      // Two-flop synchroniser; idle level is "released".
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
         end else begin
            r_s1 <= i_key_in[g];
            r_s2 <= r_s1;
         end
      end

      // The first repeat waits HOLD_MAX cycles, later ones REPEAT_MAX.
      assign w_hold_target = r_rep ? REP_LAST : HOLD_LAST;
      assign w_cnt_done    = (r_cnt == CNT_LAST);

      always_comb begin
         w_state_nxt  = r_state;
         w_cnt_nxt    = r_cnt;
         w_hold_nxt   = r_hold;
         w_rep_nxt    = r_rep;
         w_flag_nxt   = 1'b0;
         w_kstate_nxt = r_kstate;

         case (r_state)
            ST_IDLE: begin
               w_kstate_nxt = 1'b1;
               w_hold_nxt   = '0;
               w_rep_nxt    = 1'b0;
               if (!r_s2) begin
                  w_state_nxt = ST_FILT_DN;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end

            ST_FILT_DN: begin
               if (r_s2) begin
                  // Bounce: drop back without an event.
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_done) begin
                  w_state_nxt  = ST_DOWN;
                  w_flag_nxt   = 1'b1;
                  w_kstate_nxt = 1'b0;
                  w_cnt_nxt    = '0;
                  w_hold_nxt   = '0;
                  w_rep_nxt    = 1'b0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end

            ST_DOWN: begin
               w_kstate_nxt = 1'b0;
               if (r_s2) begin
                  // Release takes priority over a repeat due in this cycle.
                  w_state_nxt = ST_FILT_UP;
                  w_cnt_nxt   = CNT_W'(1);
                  w_hold_nxt  = '0;
                  w_rep_nxt   = 1'b0;
               end else if (REPEAT_EN) begin
                  if (r_hold == w_hold_target) begin
                     w_flag_nxt = 1'b1;
                     w_hold_nxt = '0;
                     w_rep_nxt  = 1'b1;
                  end else begin
                     w_hold_nxt = r_hold + 1'b1;
                  end
               end
            end

            ST_FILT_UP: begin
               if (!r_s2) begin
                  // Bounce on release: back to DOWN with the hold timer
                  // restarted, so the next repeat is a full HOLD_MAX away.
                  w_state_nxt = ST_DOWN;
                  w_cnt_nxt   = '0;
                  w_hold_nxt  = '0;
                  w_rep_nxt   = 1'b0;
               end else if (w_cnt_done) begin
                  w_state_nxt  = ST_IDLE;
                  w_flag_nxt   = 1'b1;
                  w_kstate_nxt = 1'b1;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end

            default: begin
               w_state_nxt  = ST_IDLE;
               w_cnt_nxt    = '0;
               w_hold_nxt   = '0;
               w_rep_nxt    = 1'b0;
               w_kstate_nxt = 1'b1;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_rep    <= 1'b0;
            r_flag   <= 1'b0;
            r_kstate <= 1'b1;
         end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            r_rep    <= w_rep_nxt;
            r_flag   <= w_flag_nxt;
            r_kstate <= w_kstate_nxt;
         end
      end

      assign o_key_flag[g]  = r_flag;
      assign o_key_state[g] = r_kstate;
   end : g_chan

endmodule

// File: tb/tb_key_filter.sv
// -----------------------------------------------------------------------------
// tb_key_filter
//
// Self-checking bench for key_filter with KEY_NUM=3, CNT_MAX=8, HOLD_MAX=32,
// REPEAT_MAX=16. Expected strobes (cycle and debounced level) are queued per
// channel when stimulus is driven; a negedge monitor pops and compares every
// strobe the DUT produces.
// -----------------------------------------------------------------------------
module tb_key_filter;

   localparam int KEY_NUM    = 3;
   localparam int CNT_MAX    = 8;
   localparam int HOLD_MAX   = 32;
   localparam int REPEAT_MAX = 16;
   localparam int LAT        = CNT_MAX + 2;   // drive negedge -> visible strobe

   typedef struct {
      int cyc;
      bit st;
   } ev_t;

   logic               clk;
   logic               rst_n;
   logic [KEY_NUM-1:0] key_in;
   logic [KEY_NUM-1:0] key_flag;
   logic [KEY_NUM-1:0] key_state;

   int  cyc;
   int  checks;
   int  failures;
   ev_t exp_q [KEY_NUM][$];

   key_filter #(
      .KEY_NUM   (KEY_NUM),
      .CNT_MAX   (CNT_MAX),
      .HOLD_MAX  (HOLD_MAX),
      .REPEAT_MAX(REPEAT_MAX)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_key_in   (key_in),
      .o_key_flag (key_flag),
      .o_key_state(key_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int ch, input int at, input bit st);
      ev_t e;
      e.cyc = at;
      e.st  = st;
      exp_q[ch].push_back(e);
   endtask

   // Strobe scoreboard: every flag must match the head of its channel queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int ch = 0; ch < KEY_NUM; ch++) begin
            if (key_flag[ch]) begin
               if (exp_q[ch].size() == 0) begin
                  chk($sformatf("unexpected_flag_ch%0d", ch), 1, 0);
               end else begin
                  ev_t e;
                  e = exp_q[ch].pop_front();
                  chk($sformatf("flag_cycle_ch%0d", ch), cyc, e.cyc);
                  chk($sformatf("flag_state_ch%0d", ch), int'(key_state[ch]), int'(e.st));
               end
            end
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int c;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      key_in   = 3'b111;

      // Reset state held, then keys idle after release.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_flag", int'(key_flag), 0);
         chk("rst_state", int'(key_state), 7);
      end
      rst_n = 1'b1;
      wait_neg(12);
      chk("idle_flag", int'(key_flag), 0);
      chk("idle_state", int'(key_state), 7);

      // Clean press/release on key 0, no repeat.
      c = cyc;
      key_in[0] = 1'b0;
      push(0, c + LAT, 1'b0);
      wait_neg(20);
      chk("press_state0", int'(key_state[0]), 0);
      c = cyc;
      key_in[0] = 1'b1;
      push(0, c + LAT, 1'b1);
      wait_neg(20);
      chk("release_state0", int'(key_state[0]), 1);

      // Bounce rejection on key 1.
      key_in[1] = 1'b0; wait_neg(5);
      key_in[1] = 1'b1; wait_neg(1);
      key_in[1] = 1'b0; wait_neg(5);
      key_in[1] = 1'b1; wait_neg(12);
      chk("bounce_state1", int'(key_state[1]), 1);
      c = cyc;
      key_in[1] = 1'b0;
      push(1, c + LAT, 1'b0);
      wait_neg(12);
      chk("held_state1", int'(key_state[1]), 0);
      c = cyc;
      key_in[1] = 1'b1;
      push(1, c + LAT, 1'b1);
      wait_neg(15);

      // Auto-repeat on key 2: press at edge 9, repeats at 41/57/73/89.
      c = cyc;
      key_in[2] = 1'b0;
      push(2, c + LAT, 1'b0);
      push(2, c + 1 + 41, 1'b0);
      push(2, c + 1 + 57, 1'b0);
      push(2, c + 1 + 73, 1'b0);
      push(2, c + 1 + 89, 1'b0);
      wait_neg(50);
      chk("repeat_state2", int'(key_state[2]), 0);
      wait_neg(40);
      c = cyc;
      key_in[2] = 1'b1;
      push(2, c + LAT, 1'b1);
      wait_neg(15);
      chk("repeat_release2", int'(key_state[2]), 1);

      // Simultaneous press on all keys; key 2 released into its repeat slot.
      c = cyc;
      key_in = 3'b000;
      for (int ch = 0; ch < KEY_NUM; ch++) push(ch, c + LAT, 1'b0);
      wait_neg(LAT);
      chk("simul_flag", int'(key_flag), 7);
      chk("simul_state", int'(key_state), 0);
      // Repeat is due at edge c+LAT+32; s2 reaches 1 there if key goes high
      // three cycles earlier.
      wait_neg(29);
      key_in[2] = 1'b1;
      push(2, c + 39 + LAT, 1'b1);
      push(0, c + LAT + HOLD_MAX, 1'b0);
      push(1, c + LAT + HOLD_MAX, 1'b0);
      wait_neg(6);
      key_in[1:0] = 2'b11;
      push(0, c + 45 + LAT, 1'b1);
      push(1, c + 45 + LAT, 1'b1);
      wait_neg(20);
      chk("collide_state", int'(key_state), 7);

      // Reset while key 0 is held in DOWN.
      c = cyc;
      key_in[0] = 1'b0;
      push(0, c + LAT, 1'b0);
      wait_neg(15);
      chk("pre_rst_state0", int'(key_state[0]), 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(key_state), 7);
      chk("async_rst_flag", int'(key_flag), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_flag", int'(key_flag), 0);
      end
      c = cyc;
      rst_n = 1'b1;
      push(0, c + LAT, 1'b0);
      wait_neg(14);
      chk("post_rst_state0", int'(key_state[0]), 0);
      c = cyc;
      key_in[0] = 1'b1;
      push(0, c + LAT, 1'b1);
      wait_neg(20);

      for (int ch = 0; ch < KEY_NUM; ch++)
         chk($sformatf("leftover_ch%0d", ch), exp_q[ch].size(), 0);
      chk("final_state", int'(key_state), 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
